// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Holds the pc_sequencer state encoding, the redirect source encoding used
// between redirect_arbiter and pc_sequencer, and the default reset and
// exception addresses.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0400;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

    // Wide enough for the legal DRAIN_CYCLES range 1..15.
    localparam int unsigned DRAIN_W = 4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_VECTOR
    } pc_seq_state_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_EXC,
        SRC_ERET,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_HOLD
    } redirect_src_t;

endpackage

// File: rtl/redirect_arbiter.sv
// Combinational priority select for RUN-state redirect requests.
// Priority, highest first: exception, eret, jump, branch, fetch not accepted.
// Ports:
//   exc_req, eret_req, jump_req, branch_req : redirect requests
//   accepted      : fetch at the current address was taken by decode
//   hold_target   : current fetch address, re-issued on exception or hold
//   eret_target   : saved exception PC
//   jump_target, branch_target : redirect destinations
//   src           : winning source
//   use_new, target, flush : next-cycle values for the PC block outputs
module redirect_arbiter
    import cpu_pkg::*;
(
    input  logic          exc_req,
    input  logic          eret_req,
    input  logic          jump_req,
    input  logic          branch_req,
    input  logic          accepted,
    input  logic [31:0]   hold_target,
    input  logic [31:0]   eret_target,
    input  logic [31:0]   jump_target,
    input  logic [31:0]   branch_target,
    output redirect_src_t src,
    output logic          use_new,
    output logic [31:0]   target,
    output logic          flush
);

    always_comb begin
        src     = SRC_NONE;
        use_new = 1'b0;
        target  = '0;
        flush   = 1'b0;
        if (exc_req) begin
            src     = SRC_EXC;
            use_new = 1'b1;
            target  = hold_target;
            flush   = 1'b1;
        end else if (eret_req) begin
            src     = SRC_ERET;
            use_new = 1'b1;
            target  = eret_target;
            flush   = 1'b1;
        end else if (jump_req) begin
            src     = SRC_JUMP;
            use_new = 1'b1;
            target  = jump_target;
            flush   = 1'b1;
        end else if (branch_req) begin
            src     = SRC_BRANCH;
            use_new = 1'b1;
            target  = branch_target;
            flush   = 1'b1;
        end else if (!accepted) begin
            // Re-fetch the same address; the instruction is not squashed.
            src     = SRC_HOLD;
            use_new = 1'b1;
            target  = hold_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter redirect controller.
// Drives shouldUseNewPC/newPC to the PC block each cycle from exception,
// eret, jump, branch and fetch-hold requests, and sequences exception entry
// through a DRAIN window before vectoring. All outputs are registered.
// Build option: define PC_SEQUENCER_EXC_EN to compile in the exception path
// (DRAIN/VECTOR states, epc, inException, eret). Without it excValid and
// eretValid are ignored and epc/inException read 0.
// Ports:
//   clk, rst (async, active-low)
//   pcAddress, imemReady, stall : current fetch status
//   branchTaken/branchTarget, jumpValid/jumpTarget : redirect requests
//   excValid/excPC, eretValid : exception entry and return
//   shouldUseNewPC, newPC : to PC block
//   flush : squash this cycle's fetch
//   epc, inException : exception status
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcAddress,
    input  logic        imemReady,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jumpValid,
    input  logic [31:0] jumpTarget,
    input  logic        excValid,
    input  logic [31:0] excPC,
    input  logic        eretValid,
    output logic        shouldUseNewPC,
    output logic [31:0] newPC,
    output logic        flush,
    output logic [31:0] epc,
    output logic        inException
);

    logic          accepted;
    logic [31:0]   held_q;
    redirect_src_t arb_src;
    logic          arb_use;
    logic [31:0]   arb_target;
    logic          arb_flush;
    logic          exc_req;
    logic          eret_req;
    logic          use_d;
    logic [31:0]   pc_d;
    logic          flush_d;

    assign accepted = imemReady && !stall;

    redirect_arbiter u_arb (
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .jump_req      (jumpValid),
        .branch_req    (branchTaken),
        .accepted      (accepted),
        .hold_target   (pcAddress),
        .eret_target   (epc),
        .jump_target   (jumpTarget),
        .branch_target (branchTarget),
        .src           (arb_src),
        .use_new       (arb_use),
        .target        (arb_target),
        .flush         (arb_flush)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q         <= RESET_PC;
            shouldUseNewPC <= 1'b0;
            newPC          <= '0;
            flush          <= 1'b0;
        end else begin
            held_q         <= pcAddress;
            shouldUseNewPC <= use_d;
            newPC          <= pc_d;
            flush          <= flush_d;
        end
    end

`ifdef PC_SEQUENCER_EXC_EN

    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

    pc_seq_state_t       state_q, state_d;
    logic [DRAIN_W-1:0]  cnt_q, cnt_d;
    logic [31:0]         epc_d;
    logic                inexc_d;

    assign exc_req  = excValid;
    assign eret_req = eretValid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            epc         <= '0;
            inException <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            epc         <= epc_d;
            inException <= inexc_d;
        end
    end

    // Outputs are registered, so the state in which the vector address is
    // presented (VECTOR) already arbitrates like RUN for the following cycle;
    // the vector itself is loaded on the last DRAIN cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc;
        inexc_d = inException;
        use_d   = arb_use;
        pc_d    = arb_target;
        flush_d = arb_flush;
        unique case (state_q)
            ST_RUN, ST_VECTOR: begin
                state_d = ST_RUN;
                if (arb_src == SRC_EXC) begin
                    epc_d   = excPC;
                    inexc_d = 1'b1;
                    cnt_d   = DRAIN_INIT;
                    state_d = ST_DRAIN;
                end else if (arb_src == SRC_ERET) begin
                    inexc_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                use_d   = 1'b1;
                pc_d    = held_q;
                flush_d = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == DRAIN_W'(1)) begin
                    pc_d    = EXC_VECTOR;
                    state_d = ST_VECTOR;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

`else

    localparam logic [31:0] unused_params = EXC_VECTOR ^ 32'(DRAIN_CYCLES);

    logic unused_exc;

    assign exc_req     = 1'b0;
    assign eret_req    = 1'b0;
    assign epc         = '0;
    assign inException = 1'b0;
    assign unused_exc  = ^{excValid, eretValid, excPC, held_q, arb_src};

    always_comb begin
        use_d   = arb_use;
        pc_d    = arb_target;
        flush_d = arb_flush;
    end

`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that drives the program counter's `shouldUseNewPC`/`newPC` inputs each cycle. It arbitrates redirect sources: exception, exception return, jump, branch and fetch hold. It also sequences exception entry through a fixed drain window. It sits between the execute/hazard logic and the PC block, and all of its outputs are registered.

## Interface
- `RESET_PC`, 32'h400: first fetch address after reset (PC reset value + 4).
- `EXC_VECTOR`, 32'h180: exception handler address.
- `DRAIN_CYCLES`, 2: cycles of flushed hold before vectoring; legal range 1..15.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pcAddress`  in  32  PC block's current fetch address.
- `imemReady`  in  1  instruction memory completed the fetch at `pcAddress` this cycle.
- `stall`  in  1  decode could not accept this cycle's instruction.
- `branchTaken`  in  1  resolved taken branch.
- `branchTarget`  in  32  branch destination.
- `jumpValid`  in  1  jump/jal/jr resolved.
- `jumpTarget`  in  32  jump destination.
- `excValid`  in  1  exception raised.
- `excPC`  in  32  address of the faulting instruction.
- `eretValid`  in  1  return from exception.
- `shouldUseNewPC`  out  1  to PC block.
- `newPC`  out  32  to PC block.
- `flush`  out  1  squash the instruction fetched this cycle.
- `epc`  out  32  saved exception PC.
- `inException`  out  1  high from exception acceptance until eret is applied.

## Operation
- FSM states: RUN, DRAIN, VECTOR.
- `heldPC` register: captures `pcAddress` every cycle; resets to `RESET_PC`.
- A fetch is accepted in cycle N when `imemReady && !stall`.
- All requests sampled in cycle N take effect on the outputs in cycle N+1.
- RUN priority, highest first: `excValid`, `eretValid`, `jumpValid`, `branchTaken`, not-accepted, default.
  - `excValid`: `epc <= excPC`; `inException <= 1`; counter <= `DRAIN_CYCLES`; go to DRAIN; outputs in N+1 are use=1, newPC=`heldPC`, flush=1.
  - `eretValid`: use=1, newPC=`epc`, flush=1; `inException <= 0`.
  - `jumpValid`: use=1, newPC=`jumpTarget`, flush=1.
  - `branchTaken`: use=1, newPC=`branchTarget`, flush=1.
  - Not accepted: use=1, newPC=`heldPC`, flush=0. The same address is re-fetched.
  - Default: use=0, flush=0. The PC block increments by 4.
- DRAIN:
  - Outputs are use=1, newPC=`heldPC`, flush=1.
  - Counter decrements each cycle; at 1, go to VECTOR.
  - All request inputs are ignored, including a second `excValid`.
- VECTOR: outputs are use=1, newPC=`EXC_VECTOR`, flush=1; return to RUN next cycle.
- `eretValid` while `inException`=0 still redirects to `epc`; no error is flagged.
- Targets are used verbatim. No alignment check; bits [1:0] pass through.
- Ignored inputs are not queued. Producers must re-assert after a flush.

## Timing
- Reset values:
  - FSM = RUN.
  - `shouldUseNewPC` = 0.
  - `newPC` = 32'h0.
  - `flush` = 0.
  - `epc` = 32'h0.
  - `inException` = 0.
  - `heldPC` = `RESET_PC`.
  - Drain counter = 0.
- Redirect latency: request in cycle N gives `pcAddress` = target in cycle N+1.
- Exception latency: `excValid` in cycle N gives `pcAddress` = `EXC_VECTOR` in cycle N+1+`DRAIN_CYCLES`.
- Reset asserted mid-DRAIN or mid-VECTOR: return to RUN immediately with the reset values above; no vector is issued.
- Redirect while `imemReady`=0: the target is issued once. The not-accepted rule then holds it via `heldPC` until the fetch is accepted.

## Configuration
- `PC_SEQUENCER_EXC_EN` defined: exception path compiled in (DRAIN/VECTOR states, `epc`, `inException`, eret handling).
- Undefined:
  - `excValid` and `eretValid` are ignored.
  - FSM is RUN only.
  - `epc` and `inException` are tied to 0.
  - Jump, branch and hold behaviour is unchanged.

## Structure
- Shared package `cpu_pkg`: FSM state enum `pc_seq_state_t`, `EXC_VECTOR_DEFAULT`, `RESET_PC_DEFAULT`.
- One sub-module `redirect_arbiter`: combinational priority select producing `{use, target, flush}` from the RUN-state requests. The FSM and registers stay in `pc_sequencer`.

## Test plan
- Reset release with `imemReady`=1, no requests -> `pcAddress` sequence 0x400, 0x404, 0x408; `shouldUseNewPC`=0 throughout.
- `stall`=1 for 2 cycles while `pcAddress`=0x408 -> 0x408 presented 3 times, then 0x40C; `flush`=0.
- `jumpValid` (target 0x500) and `branchTaken` (target 0x600) in the same cycle -> next `pcAddress`=0x500 with `flush`=1; then 0x504.
- `excValid` with `excPC`=0x410, `DRAIN_CYCLES`=2 -> `epc`=0x410; 2 flushed hold cycles; `pcAddress`=0x180; `jumpValid` asserted during drain has no effect; later `eretValid` -> `pcAddress`=0x410 and `inException`=0.
- `rst` asserted during DRAIN -> all outputs return to reset values asynchronously; after release `pcAddress`=0x400 and no vector is issued.
- Build without `PC_SEQUENCER_EXC_EN`: `excValid` pulse -> `pcAddress` continues +4; `epc`=0.
